noc_arbiter_merge: RTL and testbench
====================================

Name: noc_arbiter_merge

Overview:
- Clocked N-input, single-output merge with round-robin arbitration, for router output ports.
- Each input is a source channel from an input buffer: 2 inputs for W/E outputs, 4 inputs for N/S/PE outputs.
- Each packet is one atomic flit; the block forwards one flit per cycle to the output channel.
- Replaces the per-port two-input and four-input arbiter-merge blocks with one parameterised block.

Parameters:
- WIDTH, 20, packet width in bits. The PE output port instance uses WIDTH minus the stripped hop bits.
- NUM_IN, 4, number of input channels; legal values 2..8.
- SRC_W, $clog2(NUM_IN) (minimum 1), width of the source-index output. Derived; do not override.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_IN  per-input request; bit i corresponds to input Li.
- in_data  input  NUM_IN*WIDTH  packed input flits; input i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_IN  per-input accept; at most one bit high per cycle.
- out_valid  output  1  output register holds a flit.
- out_data  output  WIDTH  flit being offered downstream.
- out_src  output  SRC_W  index of the input that supplied out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Handshake:
  - A transfer occurs on a rising edge where valid and ready are both 1.
  - A sender must hold valid and data stable until the transfer.
  - in_ready may depend combinationally on in_valid and out_ready.
  - out_valid and out_data do not depend combinationally on any input; they come straight from the output register.
- Output register:
  - Load condition: load_en = !out_valid || out_ready.
  - When load_en is 1 and any in_valid is 1, the granted input's data is captured and out_valid=1 on the next edge.
  - When load_en is 1 and no in_valid is 1, out_valid goes to 0.
  - When load_en is 0, out_valid, out_data and out_src hold.
- Latency and throughput:
  - Latency is 1 cycle from the input transfer to out_valid.
  - Full throughput is 1 flit per cycle when out_ready stays 1.
- Arbitration:
  - Round-robin with a priority pointer ptr in 0..NUM_IN-1.
  - Grant goes to the first requesting input at or after ptr, searching upward modulo NUM_IN.
  - in_ready[g] = load_en && in_valid[g] for the granted g; all other in_ready bits are 0.
  - After each input transfer from g, ptr = (g+1) mod NUM_IN.
  - ptr does not change on cycles without a transfer.
- Fairness: with every input continuously requesting, grants cycle 0,1,..,N-1,0. No input waits more than NUM_IN-1 transfers.
- Simultaneous events: a flit leaving downstream and a new flit loading in the same cycle is legal; the register is replaced with no bubble.
- Backpressure:
  - While out_valid=1 and out_ready=0, all in_ready bits are 0.
  - No flit is dropped or duplicated.
- Reset:
  - Asynchronous assert: out_valid=0, out_data=0, out_src=0, ptr=0.
  - An in-flight flit in the output register is discarded.
  - in_ready is forced to 0 while rst_n=0.
  - Release is synchronised by the integrator; the block is functional on the first edge after deassertion.
- Data is forwarded unmodified; the block performs no header or hop rewriting.
- Behaviour for an in_valid that drops before its transfer is undefined (protocol violation); do not add a check for it.

Decomposition:
- Shared package noc_pkg:
  - default packet width constant (20)
  - hop-bit location constants X_HOP_LOC=4 and Y_HOP_LOC=7
  - a function clog2_min1
- One sub-module, rr_arbiter:
  - parameter NUM_IN
  - inputs req[NUM_IN], advance (transfer strobe), clk, rst_n
  - outputs grant one-hot, grant_idx, any
  - owns ptr
- Top level holds the output register and the data mux.

Test Plan:
1. Reset: assert rst_n=0 mid-transfer with out_valid=1 -> out_valid, out_src and in_ready all 0 immediately, without waiting for a clock edge. After release, send 20'hABCDE on L2 -> next cycle out_valid=1, out_data=20'hABCDE, out_src=2.
2. Round-robin: NUM_IN=4, all inputs continuously valid with data 0x1,0x2,0x3,0x4, out_ready=1 -> output sequence 0x1,0x2,0x3,0x4,0x1 on consecutive cycles, out_src 0,1,2,3,0.
3. Pointer advance: only L3 sends once, then L0 and L3 request together -> L0 granted first (ptr wrapped to 0), then L3.
4. Backpressure: out_ready=0 for 5 cycles with L1 valid=0x55 -> out_data held, in_ready=0. out_ready=1 -> exactly one transfer of 0x55 downstream, no duplicate.
5. NUM_IN=2, WIDTH=12: L0 and L1 alternate requests each cycle -> every flit delivered in order per source, 1 flit/cycle.
6. Idle: no in_valid with out_ready=1 -> out_valid drops after one cycle; ptr unchanged.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC constants and helpers for the router output-port blocks.
package noc_pkg;

  localparam int DEFAULT_WIDTH = 20;
  localparam int X_HOP_LOC     = 4;
  localparam int Y_HOP_LOC     = 7;

  // An index signal must stay at least one bit wide even for tiny counts.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/noc_arbiter_merge_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the priority
// pointer (wrapping), and moves the pointer past the winner on each transfer.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SRC_W  = clog2_min1(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  output logic [NUM_IN-1:0] grant,
  output logic [SRC_W-1:0]  grant_idx,
  output logic              any
);

  logic [SRC_W-1:0] ptr_r;
  logic [SRC_W-1:0] ptr_next_s;
  logic [SRC_W:0]   sum_s;
  logic [SRC_W-1:0] idx_s;

  // Search upward from the pointer, modulo NUM_IN; the first request wins.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    sum_s     = '0;
    idx_s     = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      sum_s = {1'b0, ptr_r} + (SRC_W+1)'(k);
      idx_s = (sum_s >= (SRC_W+1)'(NUM_IN)) ? SRC_W'(sum_s - (SRC_W+1)'(NUM_IN))
                                            : SRC_W'(sum_s);
      if (!any && req[idx_s]) begin
        any       = 1'b1;
        grant_idx = idx_s;
      end else begin
        any       = any;
      end
    end
    grant = any ? (NUM_IN'(1) << grant_idx) : '0;
  end

  // Pointer value that follows a transfer from the current winner.
  always_comb begin
    ptr_next_s = (grant_idx == SRC_W'(NUM_IN - 1)) ? '0 : grant_idx + SRC_W'(1);
  end

  // Priority pointer: moves only on an actual input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/noc_arbiter_merge.sv
// N-input single-output merge for a router output port: round-robin pick of
// one atomic flit per cycle into a registered output stage.
module noc_arbiter_merge
  import noc_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = 4,
  parameter int SRC_W  = clog2_min1(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SRC_W-1:0]        out_src,
  input  logic                    out_ready
);

  logic              load_en_s;
  logic              advance_s;
  logic              any_s;
  logic [NUM_IN-1:0] grant_s;
  logic [SRC_W-1:0]  grant_idx_s;
  logic [WIDTH-1:0]  mux_data_s;
  logic              out_valid_r;
  logic [WIDTH-1:0]  out_data_r;
  logic [SRC_W-1:0]  out_src_r;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SRC_W  (SRC_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (advance_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any       (any_s)
  );

  assign load_en_s  = !out_valid_r || out_ready;
  assign advance_s  = load_en_s && any_s;
  // Gating with rst_n keeps every input stalled while reset is held.
  assign in_ready   = (rst_n && load_en_s) ? grant_s : '0;
  assign mux_data_s = in_data[int'(grant_idx_s)*WIDTH +: WIDTH];

  // Output stage: load the winner when the slot is free or draining, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_src_r   <= '0;
    end else if (load_en_s) begin
      out_valid_r <= any_s;
      if (any_s) begin
        out_data_r <= mux_data_s;
        out_src_r  <= grant_idx_s;
      end else begin
        out_data_r <= out_data_r;
        out_src_r  <= out_src_r;
      end
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_src_r   <= out_src_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;

endmodule

// File: tb/tb_noc_arbiter_merge.sv
// Bench for noc_arbiter_merge: a 4x20 and a 2x12 instance driven with directed
// and random traffic, checked against a round-robin reference model.
module tb_noc_arbiter_merge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  va;
  logic [19:0] da [4];
  logic        ra;
  logic [1:0]  vb;
  logic [11:0] db [2];
  logic        rb;
  logic        keep;

  logic [3:0]  a_in_ready;
  logic        a_out_valid;
  logic [19:0] a_out_data;
  logic [1:0]  a_out_src;
  logic [1:0]  b_in_ready;
  logic        b_out_valid;
  logic [11:0] b_out_data;
  logic [0:0]  b_out_src;

  int total = 0;
  int bad   = 0;
  int n55   = 0;

  // reference model state per instance: pointer and output register
  int          m_ptr [2];
  logic        m_ov  [2];
  logic [19:0] m_od  [2];
  int          m_os  [2];

  always #5 clk = ~clk;

  noc_arbiter_merge #(.WIDTH(20), .NUM_IN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va),
    .in_data({da[3], da[2], da[1], da[0]}), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_src(a_out_src),
    .out_ready(ra)
  );

  noc_arbiter_merge #(.WIDTH(12), .NUM_IN(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb),
    .in_data({db[1], db[0]}), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_src(b_out_src),
    .out_ready(rb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int n, input logic [7:0] v, input int p);
    for (int k = 0; k < n; k++)
      if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  function automatic void mreset();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_ov[i] = 1'b0; m_od[i] = '0; m_os[i] = 0;
    end
  endfunction

  // one clock cycle, entered and left at the falling edge
  task automatic cycle();
    int ga, gb;
    logic lda, ldb;
    logic [3:0] era;
    logic [1:0] erb;
    #1;
    lda = !m_ov[0] || ra;
    ldb = !m_ov[1] || rb;
    ga  = pick(4, {4'b0000, va}, m_ptr[0]);
    gb  = pick(2, {6'b000000, vb}, m_ptr[1]);
    era = (lda && ga >= 0) ? 4'(1 << ga) : 4'd0;
    erb = (ldb && gb >= 0) ? 2'(1 << gb) : 2'd0;
    chk("a_ready", {28'd0, a_in_ready}, {28'd0, era});
    chk("b_ready", {30'd0, b_in_ready}, {30'd0, erb});
    if (a_out_valid && ra && a_out_data == 20'h00055) n55++;
    @(posedge clk);
    if (lda) begin
      if (ga >= 0) begin
        m_ov[0] = 1'b1; m_od[0] = da[ga]; m_os[0] = ga; m_ptr[0] = (ga + 1) % 4;
      end else m_ov[0] = 1'b0;
    end
    if (ldb) begin
      if (gb >= 0) begin
        m_ov[1] = 1'b1; m_od[1] = {8'd0, db[gb]}; m_os[1] = gb; m_ptr[1] = (gb + 1) % 2;
      end else m_ov[1] = 1'b0;
    end
    #1;
    chk("a_valid", {31'd0, a_out_valid}, {31'd0, m_ov[0]});
    chk("b_valid", {31'd0, b_out_valid}, {31'd0, m_ov[1]});
    if (m_ov[0]) begin
      chk("a_data", {12'd0, a_out_data}, {12'd0, m_od[0]});
      chk("a_src", {30'd0, a_out_src}, m_os[0]);
    end
    if (m_ov[1]) begin
      chk("b_data", {20'd0, b_out_data}, {12'd0, m_od[1]});
      chk("b_src", {31'd0, b_out_src}, m_os[1]);
    end
    @(negedge clk);
    if (!keep) begin
      va = va & ~era;
      vb = vb & ~erb;
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mreset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; keep = 1'b0;
    va = '0; vb = '0; ra = 1'b1; rb = 1'b1;
    for (int i = 0; i < 4; i++) da[i] = '0;
    for (int i = 0; i < 2; i++) db[i] = '0;
    mreset();
    repeat (2) @(negedge clk);
    chk("rst_a_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_a_data", {12'd0, a_out_data}, 32'd0);
    chk("rst_a_src", {30'd0, a_out_src}, 32'd0);
    chk("rst_b_valid", {31'd0, b_out_valid}, 32'd0);
    rst_n = 1'b1;

    // reset while a flit sits in the output register
    va = 4'b0010; da[1] = 20'h00077; ra = 1'b0;
    cycle();
    chk("pre_rst_valid", {31'd0, a_out_valid}, 32'd1);
    va = 4'hF; vb = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, a_out_valid}, 32'd0);
    chk("async_src", {30'd0, a_out_src}, 32'd0);
    chk("async_ready_a", {28'd0, a_in_ready}, 32'd0);
    chk("async_ready_b", {30'd0, b_in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mreset();
    va = 4'b0100; vb = 2'b00; da[2] = 20'hABCDE; ra = 1'b1;
    cycle();
    chk("t1_valid", {31'd0, a_out_valid}, 32'd1);
    chk("t1_data", {12'd0, a_out_data}, 32'h000ABCDE);
    chk("t1_src", {30'd0, a_out_src}, 32'd2);

    // round-robin with every input requesting
    do_reset();
    keep = 1'b1; va = 4'hF;
    for (int i = 0; i < 4; i++) da[i] = 20'(i + 1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_data", {12'd0, a_out_data}, 32'(k % 4 + 1));
      chk("rr_src", {30'd0, a_out_src}, 32'(k % 4));
    end
    keep = 1'b0; va = 4'h0;

    // pointer wraps after L3 so L0 wins the next tie
    va = 4'b1000; da[3] = 20'h00033;
    cycle();
    va = 4'b1001; da[0] = 20'h00010; da[3] = 20'h00030;
    cycle();
    chk("ptr_first", {30'd0, a_out_src}, 32'd0);
    cycle();
    chk("ptr_second", {30'd0, a_out_src}, 32'd3);

    // backpressure holds the register and stalls every input
    va = 4'b0000; n55 = 0;
    cycle();
    va = 4'b0010; da[1] = 20'h00055; ra = 1'b0;
    cycle();
    va = 4'b0100; da[2] = 20'h00066;
    repeat (5) begin
      cycle();
      chk("bp_data", {12'd0, a_out_data}, 32'h55);
      chk("bp_ready", {28'd0, a_in_ready}, 32'd0);
    end
    ra = 1'b1;
    cycle();
    chk("bp_next", {12'd0, a_out_data}, 32'h66);
    va = 4'b0000;
    cycle();
    chk("bp_once", n55, 32'd1);

    // two-input instance: alternating sources at full rate
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin vb = 2'b01; db[0] = 12'(12'h100 + k); end
      else begin vb = 2'b10; db[1] = 12'(12'h200 + k); end
      cycle();
      chk("alt_valid", {31'd0, b_out_valid}, 32'd1);
      chk("alt_data", {20'd0, b_out_data}, (k % 2 == 0) ? 32'(12'h100 + k) : 32'(12'h200 + k));
      chk("alt_src", {31'd0, b_out_src}, 32'(k % 2));
    end
    vb = 2'b00;

    // idle: output drains, pointer stays after the last winner (L2)
    repeat (2) cycle();
    chk("idle_valid", {31'd0, a_out_valid}, 32'd0);
    va = 4'hF;
    cycle();
    chk("idle_ptr", {30'd0, a_out_src}, 32'd3);
    va = 4'h0;
    cycle();

    // random traffic with random downstream stalls
    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < 4; i++)
        if (!va[i] && $urandom_range(0, 1) == 1) begin
          va[i] = 1'b1; da[i] = 20'($urandom);
        end
      for (int i = 0; i < 2; i++)
        if (!vb[i] && $urandom_range(0, 1) == 1) begin
          vb[i] = 1'b1; db[i] = 12'($urandom);
        end
      ra = ($urandom_range(0, 3) != 0);
      rb = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
